nes_reader: RTL and testbench



---
 rtl/nes_pkg.sv | 42 ++++
 rtl/bit_sync.sv | 24 ++
 rtl/nes_reader.sv | 164 ++++++++++++++++
 tb/tb_nes_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller reader.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    UPDATE
  } state_e;

  localparam int unsigned BTN_A       = 0;
  localparam int unsigned BTN_B       = 1;
  localparam int unsigned BTN_SELECT  = 2;
  localparam int unsigned BTN_START   = 3;
  localparam int unsigned BTN_UP      = 4;
  localparam int unsigned BTN_DOWN    = 5;
  localparam int unsigned BTN_LEFT    = 6;
  localparam int unsigned BTN_RIGHT   = 7;
  localparam int unsigned BIT_PRESENT = 8;
  localparam int unsigned NUM_SAMPLES = 9;
  localparam int unsigned NUM_BUTTONS = 8;
  localparam int unsigned IDX_W       = $clog2(NUM_SAMPLES);

  typedef struct packed {
    logic                   readable;
    logic [NUM_BUTTONS-1:0] buttons;
  } frame_t;

  // Turn one frame of active-low samples into button levels; a high presence bit rejects it.
  function automatic frame_t decode_frame(input logic                   present_n,
                                          input logic [NUM_BUTTONS-1:0] raw_n);
    frame_t f;
    f = '0;
    if (!present_n) begin
      f.readable = 1'b1;
      f.buttons  = ~raw_n;
    end
    return f;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous input; resets to the idle (pulled-up) level.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nes_reader.sv
// Polls a 4021-based NES controller once per poll period and publishes
// frame-consistent button levels plus a presence flag.
module nes_reader
  import nes_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES    = 1200,
  parameter int unsigned HALF_BIT_CYCLES = 600,
  parameter int unsigned POLL_CYCLES     = 1_666_667
) (
  input  logic CLK,
  input  logic RST,
  input  logic NES_DATA,
  output logic NES_LATCH,
  output logic NES_PULSE,
  output logic NA,
  output logic NB,
  output logic NSel,
  output logic NStart,
  output logic NU,
  output logic ND,
  output logic NL,
  output logic NR,
  output logic NReadable,
  output logic FrameDone
);

  localparam int unsigned PH_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES
                                                                    : HALF_BIT_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX);
  localparam int unsigned POLL_W = $clog2(POLL_CYCLES);

  state_e                 state_q, state_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [POLL_W-1:0]      poll_q, poll_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_BUTTONS-1:0] bits_q, bits_d;
  logic [NUM_BUTTONS-1:0] btn_q, btn_d;
  logic                   readable_q, readable_d;
  logic                   latch_q, latch_d;
  logic                   pulse_q, pulse_d;
  logic                   done_q, done_d;

  logic   data_s;
  logic   latch_last;
  logic   half_last;
  logic   poll_wrap;
  frame_t upd;

  bit_sync u_data_sync (
    .clk (CLK),
    .rst (RST),
    .d   (NES_DATA),
    .q   (data_s)
  );

  assign latch_last = (ph_q == PH_W'(LATCH_CYCLES - 1));
  assign half_last  = (ph_q == PH_W'(HALF_BIT_CYCLES - 1));
  assign poll_wrap  = (poll_q == POLL_W'(POLL_CYCLES - 1));
  // Presence bit is the live sample; button bits were captured earlier in the frame.
  assign upd        = decode_frame(data_s, bits_q);

  // Next-state, counters and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    idx_d      = idx_q;
    bits_d     = bits_q;
    btn_d      = btn_q;
    readable_d = readable_q;
    poll_d     = poll_wrap ? '0 : poll_q + POLL_W'(1);

    case (state_q)
      IDLE: begin
        if (poll_q == '0) begin
          state_d = LATCH;
          ph_d    = '0;
          idx_d   = '0;
        end
      end
      LATCH: begin
        if (latch_last) begin
          state_d = LOW;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      LOW: begin
        if (half_last) begin
          ph_d = '0;
          if (idx_q == IDX_W'(BIT_PRESENT)) begin
            state_d    = UPDATE;
            btn_d      = upd.buttons;
            readable_d = upd.readable;
          end else begin
            state_d             = HIGH;
            bits_d[idx_q[2:0]]  = data_s;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      HIGH: begin
        if (half_last) begin
          state_d = LOW;
          ph_d    = '0;
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    latch_d = (state_d == LATCH);
    pulse_d = (state_d == HIGH);
    done_d  = (state_d == UPDATE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      poll_q     <= '0;
      idx_q      <= '0;
      bits_q     <= '0;
      btn_q      <= '0;
      readable_q <= 1'b0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      poll_q     <= poll_d;
      idx_q      <= idx_d;
      bits_q     <= bits_d;
      btn_q      <= btn_d;
      readable_q <= readable_d;
      latch_q    <= latch_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
    end
  end

  assign NES_LATCH = latch_q;
  assign NES_PULSE = pulse_q;
  assign NA        = btn_q[BTN_A];
  assign NB        = btn_q[BTN_B];
  assign NSel      = btn_q[BTN_SELECT];
  assign NStart    = btn_q[BTN_START];
  assign NU        = btn_q[BTN_UP];
  assign ND        = btn_q[BTN_DOWN];
  assign NL        = btn_q[BTN_LEFT];
  assign NR        = btn_q[BTN_RIGHT];
  assign NReadable = readable_q;
  assign FrameDone = done_q;

endmodule

// File: tb/tb_nes_reader.sv
// Self-checking bench for nes_reader with a 4021 controller model.
module tb_nes_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic nes_data;
  logic latch, pulse;
  logic na, nb, nsel, nstart, nu, nd, nl, nr;
  logic readable, done;

  logic [7:0] btns      = 8'h00;
  logic       unplugged = 1'b0;
  logic [7:0] sr        = 8'hFF;

  nes_reader #(
    .LATCH_CYCLES    (4),
    .HALF_BIT_CYCLES (4),
    .POLL_CYCLES     (100)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .NES_DATA  (nes_data),
    .NES_LATCH (latch),
    .NES_PULSE (pulse),
    .NA        (na),
    .NB        (nb),
    .NSel      (nsel),
    .NStart    (nstart),
    .NU        (nu),
    .ND        (nd),
    .NL        (nl),
    .NR        (nr),
    .NReadable (readable),
    .FrameDone (done)
  );

  // 4021 model: parallel load on latch, shift on pulse rise, ground into the serial end.
  always @(posedge latch or posedge pulse) begin
    if (latch) sr <= ~btns;
    else       sr <= {1'b0, sr[7:1]};
  end
  assign nes_data = unplugged ? 1'b1 : sr[0];

  logic [7:0] outs;
  assign outs = {nr, nl, nd, nu, nstart, nsel, nb, na};

  int total  = 0;
  int passed = 0;

  int cyc = 0, pulse_total = 0, pulse_hi_total = 0, overlap_total = 0, mid_total = 0;
  int latch_rise = 0, prev_latch_rise = 0, done_at = 0, prev_done_at = 0;
  logic prev_pulse = 1'b0, prev_latch = 1'b0;
  logic [7:0] prev_outs = 8'h00;

  // Activity monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (pulse && !prev_pulse) pulse_total = pulse_total + 1;
    if (pulse) pulse_hi_total = pulse_hi_total + 1;
    if (pulse && latch) overlap_total = overlap_total + 1;
    if (latch && !prev_latch) begin
      prev_latch_rise = latch_rise;
      latch_rise      = cyc;
    end
    if (done) begin
      prev_done_at = done_at;
      done_at      = cyc;
    end
    if (outs != prev_outs && !done && !rst) mid_total = mid_total + 1;
    prev_pulse = pulse;
    prev_latch = latch;
    prev_outs  = outs;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    if (!done) begin
      total = total + 1;
      $display("FAIL %s: FrameDone timeout got 0 expected 1", name);
    end
  endtask

  task automatic wait_pulses(input int base, input int cnt, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((pulse_total - base) >= cnt && pulse) && n < 200);
    if (n >= 200) begin
      total = total + 1;
      $display("FAIL %s: pulse wait timeout got %0d expected %0d", name, pulse_total - base, cnt);
    end
  endtask

  // Release reset at a falling edge and track the first frame cycle by cycle.
  task automatic first_frame(input string name, input logic [7:0] exp_outs);
    int first_latch, latch_cnt, done_cyc, pbase, hbase, obase;
    logic [7:0] o_at;
    logic r_at;
    first_latch = 0; latch_cnt = 0; done_cyc = 0; o_at = 8'h00; r_at = 1'b0;
    pbase = pulse_total; hbase = pulse_hi_total; obase = overlap_total;
    rst = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (latch) begin
        latch_cnt++;
        if (first_latch == 0) first_latch = c;
      end
      if (done && done_cyc == 0) begin
        done_cyc = c;
        o_at     = outs;
        r_at     = readable;
      end
    end
    check({name, "_latch_first"}, 32'(first_latch), 32'd1);
    check({name, "_latch_len"},   32'(latch_cnt),   32'd4);
    check({name, "_done_cycle"},  32'(done_cyc),    32'd73);
    check({name, "_pulses"},      32'(pulse_total - pbase),    32'd8);
    check({name, "_pulse_hi"},    32'(pulse_hi_total - hbase), 32'd32);
    check({name, "_overlap"},     32'(overlap_total - obase),  32'd0);
    check({name, "_buttons"},     32'(o_at), 32'(exp_outs));
    check({name, "_readable"},    32'(r_at), 32'd1);
  endtask

  typedef struct {
    logic [7:0] btns;
    logic       unplugged;
    logic [7:0] exp_outs;
    logic       exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int pbase, obase, mbase;

    vecs[0] = '{8'h00, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h90, 1'b0, 8'h90, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h55, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'h09, 1'b0, 8'h09, 1'b1};
    vecs[6] = '{8'h6A, 1'b0, 8'h6A, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_latch",    32'(latch),    32'd0);
    check("rst_pulse",    32'(pulse),    32'd0);
    check("rst_buttons",  32'(outs),     32'd0);
    check("rst_readable", 32'(readable), 32'd0);
    check("rst_done",     32'(done),     32'd0);

    first_frame("f1", 8'h00);

    for (int i = 0; i < 7; i++) begin
      btns      = vecs[i].btns;
      unplugged = vecs[i].unplugged;
      pbase     = pulse_total;
      obase     = overlap_total;
      wait_done($sformatf("vec%0d", i));
      check($sformatf("vec%0d_buttons", i),  32'(outs),     32'(vecs[i].exp_outs));
      check($sformatf("vec%0d_readable", i), 32'(readable), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_pulses", i),   32'(pulse_total - pbase),   32'd8);
      check($sformatf("vec%0d_overlap", i),  32'(overlap_total - obase), 32'd0);
      check($sformatf("vec%0d_done_gap", i), 32'(done_at - prev_done_at), 32'd100);
      check($sformatf("vec%0d_latch_gap", i), 32'(latch_rise - prev_latch_rise), 32'd100);
    end
    unplugged = 1'b0;

    // Press A between frames, release once bit 0 has been sampled.
    btns  = 8'h01;
    pbase = pulse_total;
    mbase = mid_total;
    wait_pulses(pbase, 1, "a_press");
    btns = 8'h00;
    wait_done("a_frame1");
    check("a_frame1_buttons",  32'(outs),     32'h01);
    check("a_frame1_readable", 32'(readable), 32'd1);
    wait_done("a_frame2");
    check("a_frame2_buttons",  32'(outs), 32'h00);
    check("a_no_mid_change",   32'(mid_total - mbase), 32'd0);

    // Controller pulled mid-frame.
    btns = 8'h3C;
    wait_done("unplug_pre");
    check("unplug_pre_buttons", 32'(outs), 32'h3C);
    pbase = pulse_total;
    wait_pulses(pbase, 3, "unplug_wait");
    unplugged = 1'b1;
    wait_done("unplug");
    check("unplug_buttons",  32'(outs),     32'h00);
    check("unplug_readable", 32'(readable), 32'd0);
    unplugged = 1'b0;

    // Reset during the third pulse, then a clean frame.
    btns = 8'hFF;
    wait_done("rst_mid_pre");
    wait_done("rst_mid_pre2");
    check("rst_mid_pre_buttons", 32'(outs), 32'hFF);
    pbase = pulse_total;
    wait_pulses(pbase, 3, "rst_mid_wait");
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pulse",    32'(pulse),    32'd0);
    check("rst_mid_latch",    32'(latch),    32'd0);
    check("rst_mid_buttons",  32'(outs),     32'd0);
    check("rst_mid_readable", 32'(readable), 32'd0);
    check("rst_mid_done",     32'(done),     32'd0);
    repeat (2) @(negedge clk);
    first_frame("f_after_rst", 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
